cell_split: RTL and testbench
=============================

CELL_SPLIT -- requirements
Module: cell_split

Interface
REQ-001 Parameter CH_NUM, default 16: number of channels carried; chnum values 0..CH_NUM-1 are legal.
REQ-002 Parameter MAX_DLY, default 23: maximum cell1 skew in cycles, equal to the comb alignment window.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports below.
REQ-004 clk  input  1  block clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 comb_vld_in  input  1  combined sample valid.
REQ-007 comb_chnum_in  input  4  channel number of the combined sample.
REQ-008 comb_data_in  input  32  [15:0] carries the cell0 sample; [31:16] carries the cell1 sample.
REQ-009 comb_10ms_timer_in  input  1  single-cycle 10 ms frame pulse.
REQ-010 cfg_cell1_dly  input  5  cell1 skew in cycles, 0..MAX_DLY.
REQ-011 cell0_vld_out, cell1_vld_out  output  1  per-cell sample valid.
REQ-012 cell0_chnum_out, cell1_chnum_out  output  4  per-cell channel number.
REQ-013 cell0_data_out, cell1_data_out  output  16  per-cell sample.
REQ-014 cell0_10ms_timer, cell1_10ms_timer  output  1  per-channel frame marker, qualified by the matching vld.
REQ-015 chnum_err  output  1  one-cycle pulse when an illegal chnum is dropped.
REQ-016 sync_lost  output  1  sticky flag; cleared only by reset.

Function
REQ-017 FSM states SHALL be SEARCH (the reset state) and RUN.
- SEARCH -> RUN on comb_10ms_timer_in.
- In SEARCH, all samples SHALL be discarded and no vld SHALL be output.
REQ-018 On SEARCH->RUN, and on every later timer pulse, cfg_cell1_dly SHALL be latched; a value greater than MAX_DLY SHALL be clamped to MAX_DLY.
- The latched value is the only delay in use; cfg changes between pulses have no effect.
REQ-019 A pending vector pend[CH_NUM-1:0] SHALL be set to all-ones on each timer pulse.
- A legal valid sample of channel k SHALL carry timer = pend[k] and SHALL clear pend[k].
REQ-020 When a timer pulse coincides with a valid sample of channel k:
- that sample SHALL be tagged;
- pend SHALL become all-ones except bit k.
REQ-021 When a timer pulse arrives while any pend bit is still set:
- sync_lost SHALL be set;
- the pend vector SHALL be reloaded.
REQ-022 When comb_chnum_in >= CH_NUM with comb_vld_in=1:
- the sample SHALL be dropped from both cells;
- chnum_err SHALL pulse on the next cycle;
- pend SHALL be unchanged.
REQ-023 Cell0 path: vld, chnum, data[15:0] and the tag SHALL appear at the cell0 outputs exactly 1 cycle after the input cycle.
REQ-024 Cell1 path: the same sample, with data[31:16] and the same tag, SHALL appear exactly 1+D cycles after the input cycle, where D is the latched delay.
REQ-025 The delay line SHALL be MAX_DLY+1 entries of {vld, chnum, data, tag}.
- It is read at tap D and advances every cycle, with or without valid input.
REQ-026 When D changes at a timer pulse, entries already in the line SHALL be output at the old tap until the line flushes.
- Samples may be lost or duplicated only within that D-cycle window; ordering SHALL otherwise be preserved.
REQ-027 Back-to-back valid samples on every cycle SHALL be supported with no stalls; there is no backpressure.

Reset
REQ-028 On rst_n low, all outputs SHALL be 0 asynchronously, the FSM SHALL be in SEARCH, pend SHALL be 0, the delay line SHALL be cleared (vld=0), and the latched D SHALL be 0.
REQ-029 A reset mid-stream SHALL discard all in-flight samples; the next output SHALL be produced only after a new timer pulse.

Structure
REQ-030 A shared package SHALL hold CH_NUM, MAX_DLY, the FSM state typedef, and the delay-entry record width (1+4+16+1 bits).
REQ-031 The delay line SHALL be a sub-module, cell_dly_line, parameterized by depth and width, with a tap-select input.

Verification
REQ-032 Reset, timer pulse, then ch0..15 on consecutive cycles with D=0 -> both cells show identical chnum 0..15 one cycle later, tag=1 on each first sample, and tag=0 on the second pass.
REQ-033 cfg_cell1_dly=23, timer, then a ch0 sample with data 0xBBBB_AAAA -> cell0 outputs 0xAAAA at +1 cycle; cell1 outputs 0xBBBB at +24 cycles; both tagged.
REQ-034 Timer coincident with a ch5 sample -> ch5 tagged in that cycle; the next ch5 sample is untagged; the next ch6 sample is tagged.
REQ-035 chnum=4'hF with CH_NUM=12 -> no vld on either cell, and chnum_err=1 for one cycle.
REQ-036 Two timer pulses with only ch0 sent in between -> sync_lost=1 and it stays set; cfg_cell1_dly=31 latches as 23.
REQ-037 Reset asserted with 10 samples in the cell1 line -> no cell1 vld after release until a new timer pulse plus 1+D cycles.

Source files
------------

// File: rtl/cell_split_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cell_split_pkg
// Brief    : Shared constants, FSM state type and delay-entry record for
//            the combined-to-per-cell sample splitter.
// Revision : 1.0 - initial release
// ============================================================================
package cell_split_pkg;

    localparam int CH_NUM    = 16;
    localparam int MAX_DLY   = 23;

    localparam int c_chnum_w = 4;
    localparam int c_data_w  = 16;
    localparam int c_dly_w   = 5;
    localparam int c_entry_w = 1 + c_chnum_w + c_data_w + 1;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        RUN    = 1'b1
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic [c_chnum_w-1:0] chnum;
        logic [c_data_w-1:0]  data;
        logic                 tag;
    } dly_entry_t;

    function automatic logic [c_dly_w-1:0] clamp_dly(
        input logic [c_dly_w-1:0] cfg,
        input int                 max_dly
    );
        if (int'(cfg) > max_dly) begin
            return c_dly_w'(max_dly);
        end
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_dly_line.sv
`default_nettype none
// ============================================================================
// Module   : cell_dly_line
// Brief    : Free-running shift line with a selectable read tap.
// Revision : 1.0 - initial release
// ============================================================================
module cell_dly_line #(
    parameter int DEPTH = 24,
    parameter int WIDTH = 22,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Advances every cycle; idle cycles push empty entries through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[sel];

endmodule
`default_nettype wire

// File: rtl/cell_split.sv
`default_nettype none
// ============================================================================
// Module   : cell_split
// Brief    : Splits combined two-cell samples into a cell0 stream (+1 cycle)
//            and a skew-delayed cell1 stream, tagging each channel's first
//            sample after every 10 ms frame pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cell_split #(
    parameter int CH_NUM  = cell_split_pkg::CH_NUM,
    parameter int MAX_DLY = cell_split_pkg::MAX_DLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        comb_vld_in,
    input  logic [3:0]  comb_chnum_in,
    input  logic [31:0] comb_data_in,
    input  logic        comb_10ms_timer_in,
    input  logic [4:0]  cfg_cell1_dly,
    output logic        cell0_vld_out,
    output logic [3:0]  cell0_chnum_out,
    output logic [15:0] cell0_data_out,
    output logic        cell0_10ms_timer,
    output logic        cell1_vld_out,
    output logic [3:0]  cell1_chnum_out,
    output logic [15:0] cell1_data_out,
    output logic        cell1_10ms_timer,
    output logic        chnum_err,
    output logic        sync_lost
);

    import cell_split_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_NUM-1:0]   r_pend;
    logic [CH_NUM-1:0]   w_pend_nxt;
    logic [CH_NUM-1:0]   w_ch_onehot;
    logic                w_legal;
    logic                w_accept;
    logic                w_tag;
    logic                w_sync_hit;
    logic                w_chnum_bad;
    logic                r_sync_lost;
    logic                r_chnum_err;
    dly_entry_t          w_entry0;
    dly_entry_t          w_entry1;
    dly_entry_t          r_cell0;
    dly_entry_t          w_cell1;
    logic [c_dly_w-1:0]  w_cfg_clamped;
    logic [c_dly_w-1:0]  r_tap;
    logic [c_dly_w-1:0]  r_dly_new;
    logic [c_dly_w-1:0]  r_flush_cnt;

    assign w_legal       = ({1'b0, comb_chnum_in} < 5'(CH_NUM));
    assign w_ch_onehot   = CH_NUM'(1) << comb_chnum_in;
    assign w_cfg_clamped = clamp_dly(cfg_cell1_dly, MAX_DLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A sample coinciding with a pulse in RUN opens the new frame, so it is
    // tagged and its channel is immediately cleared from the reloaded vector.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_accept    = 1'b0;
        w_tag       = 1'b0;
        w_sync_hit  = 1'b0;
        w_chnum_bad = 1'b0;
        case (r_state)
            SEARCH: begin
                if (comb_10ms_timer_in) begin
                    w_state_nxt = RUN;
                    w_pend_nxt  = '1;
                end
            end
            RUN: begin
                w_accept    = comb_vld_in & w_legal;
                w_chnum_bad = comb_vld_in & ~w_legal;
                if (comb_10ms_timer_in) begin
                    w_sync_hit = |r_pend;
                    w_pend_nxt = '1;
                    w_tag      = 1'b1;
                end else begin
                    w_tag = |(r_pend & w_ch_onehot);
                end
                if (w_accept) begin
                    w_pend_nxt = w_pend_nxt & ~w_ch_onehot;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    always_comb begin
        w_entry0 = '0;
        w_entry1 = '0;
        if (w_accept) begin
            w_entry0.vld   = 1'b1;
            w_entry0.chnum = comb_chnum_in;
            w_entry0.data  = comb_data_in[15:0];
            w_entry0.tag   = w_tag;
            w_entry1       = w_entry0;
            w_entry1.data  = comb_data_in[31:16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_cell0     <= '0;
            r_sync_lost <= 1'b0;
            r_chnum_err <= 1'b0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_cell0     <= w_entry0;
            r_sync_lost <= r_sync_lost | w_sync_hit;
            r_chnum_err <= w_chnum_bad;
        end
    end

    // A new delay takes effect only after the old tap has drained the
    // entries already in the line (old-D cycles after the pulse).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap       <= '0;
            r_dly_new   <= '0;
            r_flush_cnt <= '0;
        end else if (comb_10ms_timer_in) begin
            r_dly_new <= w_cfg_clamped;
            if (r_tap == '0) begin
                r_tap       <= w_cfg_clamped;
                r_flush_cnt <= '0;
            end else begin
                r_flush_cnt <= r_tap;
            end
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
            if (r_flush_cnt == c_dly_w'(1)) begin
                r_tap <= r_dly_new;
            end
        end
    end

    cell_dly_line #(
        .DEPTH (MAX_DLY + 1),
        .WIDTH (c_entry_w),
        .SEL_W (c_dly_w)
    ) u_cell1_line (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (w_entry1),
        .sel   (r_tap),
        .dout  (w_cell1)
    );

    assign cell0_vld_out    = r_cell0.vld;
    assign cell0_chnum_out  = r_cell0.chnum;
    assign cell0_data_out   = r_cell0.data;
    assign cell0_10ms_timer = r_cell0.tag;

    assign cell1_vld_out    = w_cell1.vld;
    assign cell1_chnum_out  = w_cell1.chnum;
    assign cell1_data_out   = w_cell1.data;
    assign cell1_10ms_timer = w_cell1.tag;

    assign chnum_err        = r_chnum_err;
    assign sync_lost        = r_sync_lost;

endmodule
`default_nettype wire

// File: tb/tb_cell_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_split
// Brief    : Self-checking bench for cell_split: two instances (16 and 12
//            channels) driven in parallel against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_split;

    import cell_split_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_in = 1'b0;
    logic [3:0]  ch_in = '0;
    logic [31:0] data_in = '0;
    logic        tmr_in = 1'b0;
    logic [4:0]  cfg_in = '0;

    logic        c0v [2];
    logic        c1v [2];
    logic        c0t [2];
    logic        c1t [2];
    logic [3:0]  c0c [2];
    logic [3:0]  c1c [2];
    logic [15:0] c0d [2];
    logic [15:0] c1d [2];
    logic        errp [2];
    logic        slost [2];

    int          errors = 0;
    int          checks = 0;
    bit          cmp_en = 1'b0;

    // model state
    int          cyc = 1000;
    int          ch_lim [2] = '{16, 12};
    bit          m_run [2];
    logic [15:0] m_pend [2];
    bit          m_sync [2];
    int          m_tap [2];
    int          m_new [2];
    int          m_sw_at [2];
    dly_entry_t  hist [2][64];
    dly_entry_t  x0 [2];
    dly_entry_t  x1 [2];
    bit          xerr [2];

    always #5 clk = ~clk;

    cell_split u_dut16 (
        .clk                (clk),
        .rst_n              (rst_n),
        .comb_vld_in        (vld_in),
        .comb_chnum_in      (ch_in),
        .comb_data_in       (data_in),
        .comb_10ms_timer_in (tmr_in),
        .cfg_cell1_dly      (cfg_in),
        .cell0_vld_out      (c0v[0]),
        .cell0_chnum_out    (c0c[0]),
        .cell0_data_out     (c0d[0]),
        .cell0_10ms_timer   (c0t[0]),
        .cell1_vld_out      (c1v[0]),
        .cell1_chnum_out    (c1c[0]),
        .cell1_data_out     (c1d[0]),
        .cell1_10ms_timer   (c1t[0]),
        .chnum_err          (errp[0]),
        .sync_lost          (slost[0])
    );

    cell_split #(.CH_NUM(12)) u_dut12 (
        .clk                (clk),
        .rst_n              (rst_n),
        .comb_vld_in        (vld_in),
        .comb_chnum_in      (ch_in),
        .comb_data_in       (data_in),
        .comb_10ms_timer_in (tmr_in),
        .cfg_cell1_dly      (cfg_in),
        .cell0_vld_out      (c0v[1]),
        .cell0_chnum_out    (c0c[1]),
        .cell0_data_out     (c0d[1]),
        .cell0_10ms_timer   (c0t[1]),
        .cell1_vld_out      (c1v[1]),
        .cell1_chnum_out    (c1c[1]),
        .cell1_data_out     (c1d[1]),
        .cell1_10ms_timer   (c1t[1]),
        .chnum_err          (errp[1]),
        .sync_lost          (slost[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]   = 1'b0;
            m_pend[i]  = '0;
            m_sync[i]  = 1'b0;
            m_tap[i]   = 0;
            m_new[i]   = 0;
            m_sw_at[i] = -1;
            x0[i]      = '0;
            x1[i]      = '0;
            xerr[i]    = 1'b0;
            for (int j = 0; j < 64; j++) hist[i][j] = '0;
        end
    endtask

    // Frame rules applied to the inputs sampled at this rising edge.
    task automatic model_step();
        dly_entry_t  e0;
        dly_entry_t  e1;
        bit          legal;
        bit          tg;
        logic [15:0] mask;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            e0      = '0;
            e1      = '0;
            xerr[i] = 1'b0;
            legal   = int'(ch_in) < ch_lim[i];
            mask    = 16'((33'h1 << ch_lim[i]) - 1);
            if (m_run[i]) begin
                if (vld_in && !legal) xerr[i] = 1'b1;
                if (vld_in && legal) begin
                    tg = tmr_in ? 1'b1 : m_pend[i][ch_in];
                    e0 = '{vld: 1'b1, chnum: ch_in, data: data_in[15:0], tag: tg};
                    e1 = '{vld: 1'b1, chnum: ch_in, data: data_in[31:16], tag: tg};
                end
                if (tmr_in) begin
                    if (m_pend[i] != 0) m_sync[i] = 1'b1;
                    m_pend[i] = mask;
                end
                if (vld_in && legal) m_pend[i][ch_in] = 1'b0;
            end else if (tmr_in) begin
                m_run[i]  = 1'b1;
                m_pend[i] = mask;
            end
            if (tmr_in) begin
                m_new[i] = (int'(cfg_in) > MAX_DLY) ? MAX_DLY : int'(cfg_in);
                if (m_tap[i] == 0) begin
                    m_tap[i]   = m_new[i];
                    m_sw_at[i] = -1;
                end else begin
                    m_sw_at[i] = cyc + m_tap[i];
                end
            end else if (cyc == m_sw_at[i]) begin
                m_tap[i]   = m_new[i];
                m_sw_at[i] = -1;
            end
            hist[i][cyc % 64] = e1;
            x0[i] = e0;
            x1[i] = hist[i][(cyc - m_tap[i]) % 64];
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d cell0_vld", i), 32'(c0v[i]), 32'(x0[i].vld));
                if (x0[i].vld) begin
                    chk($sformatf("u%0d cell0_chnum", i), 32'(c0c[i]), 32'(x0[i].chnum));
                    chk($sformatf("u%0d cell0_data", i), 32'(c0d[i]), 32'(x0[i].data));
                    chk($sformatf("u%0d cell0_tag", i), 32'(c0t[i]), 32'(x0[i].tag));
                end
                chk($sformatf("u%0d cell1_vld", i), 32'(c1v[i]), 32'(x1[i].vld));
                if (x1[i].vld) begin
                    chk($sformatf("u%0d cell1_chnum", i), 32'(c1c[i]), 32'(x1[i].chnum));
                    chk($sformatf("u%0d cell1_data", i), 32'(c1d[i]), 32'(x1[i].data));
                    chk($sformatf("u%0d cell1_tag", i), 32'(c1t[i]), 32'(x1[i].tag));
                end
                chk($sformatf("u%0d chnum_err", i), 32'(errp[i]), 32'(xerr[i]));
                chk($sformatf("u%0d sync_lost", i), 32'(slost[i]), 32'(m_sync[i]));
            end
        end
    end

    task automatic step(input bit v, input logic [3:0] ch, input logic [31:0] d,
                        input bit t, input logic [4:0] cfg);
        vld_in  = v;
        ch_in   = ch;
        data_in = d;
        tmr_in  = t;
        cfg_in  = cfg;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 32'd0, 1'b0, cfg_in);
    endtask

    task automatic do_reset(input int n);
        #2;
        rst_n  = 1'b0;
        vld_in = 1'b0;
        tmr_in = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset cell0_vld", 32'(c0v[0]), 32'd0);
        chk("reset sync_lost", 32'(slost[0]), 32'd0);
        #2;
        rst_n = 1'b1;

        // first frame, D=0: both cells carry ch0..15, tagged on pass 0 only
        step(1'b0, 4'd0, 32'd0, 1'b1, 5'd0);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 16; k++) begin
                step(1'b1, 4'(k), {16'(k + 'h100), 16'(k)}, 1'b0, 5'd0);
                chk("pass cell0 chnum", 32'(c0c[0]), 32'(k));
                chk("pass cell1 chnum", 32'(c1c[0]), 32'(k));
                chk("pass cell0 tag", 32'(c0t[0]), (p == 0) ? 32'd1 : 32'd0);
                chk("pass cell1 tag", 32'(c1t[0]), (p == 0) ? 32'd1 : 32'd0);
                if (k >= 12) chk("u1 illegal err", 32'(errp[1]), 32'd1);
            end
        end

        // D=23: cell0 at +1, cell1 at +24
        step(1'b0, 4'd0, 32'd0, 1'b1, 5'd23);
        step(1'b1, 4'd0, 32'hBBBB_AAAA, 1'b0, 5'd23);
        chk("d23 cell0 data", 32'(c0d[0]), 32'h0000_AAAA);
        chk("d23 cell0 tag", 32'(c0t[0]), 32'd1);
        idle(22);
        chk("d23 cell1 early", 32'(c1v[0]), 32'd0);
        idle(1);
        chk("d23 cell1 vld", 32'(c1v[0]), 32'd1);
        chk("d23 cell1 data", 32'(c1d[0]), 32'h0000_BBBB);
        chk("d23 cell1 tag", 32'(c1t[0]), 32'd1);

        // only ch0 seen in this frame -> sync lost; cfg 31 clamps to 23
        chk("sync before", 32'(slost[0]), 32'd0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 5'd31);
        chk("sync set", 32'(slost[0]), 32'd1);
        idle(30);
        chk("sync sticky", 32'(slost[0]), 32'd1);
        step(1'b1, 4'd1, 32'hCCCC_1111, 1'b0, 5'd31);
        idle(23);
        chk("clamp cell1 vld", 32'(c1v[0]), 32'd1);
        chk("clamp cell1 data", 32'(c1d[0]), 32'h0000_CCCC);

        // pulse coincident with ch5
        step(1'b1, 4'd5, 32'h5555_0005, 1'b1, 5'd0);
        chk("coinc ch5 tag", 32'(c0t[0]), 32'd1);
        step(1'b1, 4'd5, 32'h5555_0006, 1'b0, 5'd0);
        chk("second ch5 tag", 32'(c0t[0]), 32'd0);
        step(1'b1, 4'd6, 32'h6666_0006, 1'b0, 5'd0);
        chk("first ch6 tag", 32'(c0t[0]), 32'd1);

        // illegal chnum on the 12-channel instance
        step(1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 5'd0);
        chk("ill cell0 vld", 32'(c0v[1]), 32'd0);
        chk("ill err pulse", 32'(errp[1]), 32'd1);
        idle(1);
        chk("ill err clear", 32'(errp[1]), 32'd0);

        // reset with samples in the cell1 line
        idle(25);
        step(1'b0, 4'd0, 32'd0, 1'b1, 5'd23);
        for (int k = 0; k < 10; k++) step(1'b1, 4'(k), $urandom, 1'b0, 5'd23);
        do_reset(2);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 4'(k % 16), $urandom, 1'b0, 5'd23);
            chk("post-reset cell1 quiet", 32'(c1v[0]), 32'd0);
        end
        step(1'b0, 4'd0, 32'd0, 1'b1, 5'd4);
        step(1'b1, 4'd3, 32'h3333_0303, 1'b0, 5'd4);
        idle(3);
        chk("restart cell1 early", 32'(c1v[0]), 32'd0);
        idle(1);
        chk("restart cell1 vld", 32'(c1v[0]), 32'd1);
        chk("restart cell1 chnum", 32'(c1c[0]), 32'd3);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 1999) == 0) do_reset(1 + $urandom_range(0, 2));
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 39) == 0, 5'($urandom_range(0, 31)));
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
